wrr_arbiter: RTL
================

Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It is the successor to the fixed 4-way round-robin arbiter, generalised to N requesters with a per-requester burst quota (weight). Each winner holds the grant for up to weight consecutive cycles while it keeps requesting, then priority rotates to the next index. It sits between N request sources and a shared resource (bus, memory port, FIFO write side).

Parameters:
N, 4, number of requesters (2..32)
WW, 4, width of each weight field in bits
IW, $clog2(N), width of gnt_id

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  N  request vector, bit i = requester i
weight  input  N*WW  packed weights, weight[i*WW +: WW] = burst quota of requester i
gnt  output  N  registered one-hot grant
gnt_id  output  IW  binary index of the granted requester, 0 when no grant
gnt_valid  output  1  high when any gnt bit is set (equals OR of gnt)

Behaviour:
- Reset (async, rst=1): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, cnt=0, state=IDLE. Outputs clear immediately, without waiting for a clock edge.
- State: ptr (IW bits, the highest-priority index), owner (IW bits), cnt (WW bits, remaining extra grants), FSM {IDLE, GRANT}.
- Search function: scan the indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first index with req set wins. Wrap-around is mod N, including non-power-of-2 N.
- IDLE:
  - If req==0, stay in IDLE with outputs 0.
  - Otherwise, winner w = search(req). On the next edge: gnt=onehot(w), gnt_id=w, owner=w, cnt=eff_weight(w)-1, state=GRANT.
  - Latency from req rising to gnt is exactly 1 cycle.
- eff_weight(i) = weight field i, except that 0 is treated as 1. The weight is sampled only at the grant edge. Changes during a burst have no effect on the current burst.
- GRANT, owner k:
  - Hold condition: req[k]=1 and cnt!=0. Then cnt decrements and gnt is unchanged.
  - Release condition: req[k]=0 or cnt==0. Then ptr = (k+1) mod N and a new search runs from that ptr in the same cycle, using the current req.
    - If a winner is found, the new grant is issued on the next edge with no idle gap, and cnt is reloaded.
    - If none is found, gnt goes to 0 and state returns to IDLE.
  - Because the search starts at k+1, k is regranted only when it is the sole requester. In that case k gets a fresh quota and its gnt stays high continuously.
- Requester protocol: the grant is consumed in every cycle gnt[i]=1. A requester ends its burst by deasserting req. It then still sees gnt for that one cycle, and gnt is removed on the next edge.
- gnt is always one-hot or zero. gnt_id and gnt_valid are always consistent with gnt.
- A req bit set for a non-owner never preempts the owner mid-burst.
- Reset mid-burst discards owner, cnt and ptr. After release, the first grant comes from a search starting at index 0.

Test Plan:
1. N=4, all weights=1, req=1111 held from reset release: gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles. The first grant appears 1 cycle after req.
2. N=4, weight0=3, weights1..3=1, req=1111 held: gnt = 0001 ×3, then 0010, 0100, 1000, then 0001 ×3 again. gnt_id tracks 0,0,0,1,2,3,0.
3. N=4, weight0=4, req=0011; drop req[0] after its first grant cycle: gnt 0001 for 2 cycles (drop plus 1 cycle), then 0010. ptr moves to 1.
4. N=4, weight2=2, req=0100 only, held 6 cycles: gnt=0100 continuously with no gap. Quota reload is visible internally as cnt 1,0,1,0.
5. Weight=0 edge case: weight1=0, req=0010: 1-cycle bursts, behaving exactly like weight=1. Then set req=0000: gnt=0000 and gnt_valid=0 one cycle later.
6. Reset mid-burst: weight3=5, req=1001, grant at 1000. Assert rst mid-burst: gnt=0000 immediately, before the next edge. Release rst with req=1001: the next grant is 0001, because ptr was reset to 0.

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// Each winner keeps the grant for up to its weight in consecutive cycles while it keeps
// requesting. Priority then rotates to the index after the owner. Grants are registered and
// are always one-hot or zero.
module wrr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned WW = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   output logic [N-1:0]    gnt,
   output logic [IW-1:0]   gnt_id,
   output logic            gnt_valid
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [WW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic          gnt_valid_q, gnt_valid_d;

   logic [IW-1:0] owner_nxt;
   logic [IW-1:0] search_ptr;
   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [N-1:0]  win_onehot;
   logic [WW-1:0] win_weight;
   logic [WW-1:0] win_cnt;

   // Index following the current owner, wrapping mod N (N need not be a power of two).
   always_comb begin
      owner_nxt = owner_q + IW'(1);
      if (32'(owner_q) == N - 1) begin
         owner_nxt = '0;
      end
   end

   // While granting, a search is only consumed on release, so it always starts past the owner.
   always_comb begin
      search_ptr = ptr_q;
      if (state_q == StGrant) begin
         search_ptr = owner_nxt;
      end
   end

   // Rotating priority search: first requester at or after search_ptr, wrapping mod N.
   always_comb begin
      int unsigned pos;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = 0;
      for (int unsigned off = 0; off < N; off++) begin
         pos = 32'(search_ptr) + off;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!win_found && req[pos[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = IW'(pos);
         end
      end
   end

   // Winner decode and quota load; a zero weight behaves as a weight of one.
   always_comb begin
      win_onehot = N'(1) << win_idx;
      win_weight = weight[32'(win_idx)*WW +: WW];
      if (win_weight == '0) begin
         win_cnt = '0;
      end else begin
         win_cnt = win_weight - WW'(1);
      end
   end

   // Next-state logic: start bursts from idle, hold or release while granting.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;

      unique case (state_q)
         StIdle: begin
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            if (win_found) begin
               state_d     = StGrant;
               owner_d     = win_idx;
               cnt_d       = win_cnt;
               gnt_d       = win_onehot;
               gnt_id_d    = win_idx;
               gnt_valid_d = 1'b1;
            end
         end

         StGrant: begin
            if (req[owner_q] && (cnt_q != '0)) begin
               // Burst continues; other requesters cannot preempt the owner.
               cnt_d = cnt_q - WW'(1);
            end else begin
               // Release: rotate priority and hand over in the same cycle, no idle gap.
               ptr_d = owner_nxt;
               if (win_found) begin
                  owner_d     = win_idx;
                  cnt_d       = win_cnt;
                  gnt_d       = win_onehot;
                  gnt_id_d    = win_idx;
                  gnt_valid_d = 1'b1;
               end else begin
                  state_d     = StIdle;
                  cnt_d       = '0;
                  gnt_d       = '0;
                  gnt_id_d    = '0;
                  gnt_valid_d = 1'b0;
               end
            end
         end

         default: begin
            state_d     = StIdle;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears the grant without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;

endmodule
